// File: rtl/me_pkg.sv
// Shared widths, default parameters and result-entry layout for the
// math_expression issue/collect block.
package me_pkg;

    localparam int unsigned ME_W_DEF     = 32'd16;
    localparam int unsigned ME_DEPTH_DEF = 32'd4;
    localparam int unsigned ME_TAG_W_DEF = 32'd4;

    // Quotient width returned by math_expression for operand width w.
    function automatic int unsigned qw(input int unsigned w);
        return 32'd2 * w + 32'd4;
    endfunction

    // Result entries are packed {q, rmd, tag} with q in the MSBs.
    function automatic int unsigned res_w(input int unsigned w, input int unsigned tag_w);
        return qw(w) + 32'd1 + tag_w;
    endfunction

endpackage

// File: rtl/me_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and a
// synchronous active-low reset; the head reads as zero while empty.
module me_sync_fifo #(
    parameter int unsigned DW    = 32'd8,
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   wr_q;
    logic [AW:0]   wr_d;
    logic [AW:0]   rd_q;
    logic [AW:0]   rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push_s;
    logic          do_pop_s;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // Guarded pointer advance; the extra pointer bit wraps modulo 2*DEPTH.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        if (do_push_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

    // Fall-through head.
    always_comb begin
        if (empty_o) begin
            dout_o = '0;
        end else begin
            dout_o = mem_q[rd_q[AW-1:0]];
        end
    end

endmodule

// File: rtl/me_issue_collect.sv
// Issues operand tuples to math_expression and collects its results in order,
// tagged, onto a valid/ready stream; credits keep the result buffer from overflowing.
module me_issue_collect
    import me_pkg::*;
#(
    parameter  int unsigned W     = ME_W_DEF,
    parameter  int unsigned DEPTH = ME_DEPTH_DEF,
    parameter  int unsigned TAG_W = ME_TAG_W_DEF,
    localparam int unsigned QW    = qw(W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_c,
    input  logic [W-1:0]     in_d,
    input  logic [TAG_W-1:0] in_tag,
    output logic             me_start,
    output logic [W-1:0]     me_a,
    output logic [W-1:0]     me_b,
    output logic [W-1:0]     me_c,
    output logic [W-1:0]     me_d,
    input  logic             me_valid,
    input  logic [QW-1:0]    me_q,
    input  logic             me_rmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    out_q,
    output logic             out_rmd,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CW = $clog2(DEPTH + 32'd1);
    localparam int unsigned RW = res_w(W, TAG_W);

    logic [CW-1:0]    credit_q;
    logic [CW-1:0]    credit_d;
    logic [CW-1:0]    inflight_q;
    logic [CW-1:0]    inflight_d;
    logic             err_q;
    logic             err_d;
    logic             start_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     c_q;
    logic [W-1:0]     d_q;

    logic             accept_s;
    logic             pop_s;
    logic             collect_s;
    logic [TAG_W-1:0] tag_head_s;
    logic             tag_empty_s;
    logic             tag_full_s;
    logic [RW-1:0]    res_din_s;
    logic [RW-1:0]    res_head_s;
    logic             res_empty_s;
    logic             res_full_s;
    logic             unused_s;

    assign in_ready  = reset && (credit_q != '0);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = !res_empty_s;
    assign pop_s     = out_valid && out_ready;
    assign collect_s = me_valid && (inflight_q != '0);
    assign res_din_s = {me_q, me_rmd, tag_head_s};

    // Both FIFOs only fill under credit control, so their status flags carry no extra information.
    assign unused_s = tag_empty_s ^ tag_full_s ^ res_full_s;

    me_sync_fifo #(
        .DW    (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (accept_s),
        .din_i   (in_tag),
        .pop_i   (collect_s),
        .dout_o  (tag_head_s),
        .empty_o (tag_empty_s),
        .full_o  (tag_full_s)
    );

    me_sync_fifo #(
        .DW    (RW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (collect_s),
        .din_i   (res_din_s),
        .pop_i   (pop_s),
        .dout_o  (res_head_s),
        .empty_o (res_empty_s),
        .full_o  (res_full_s)
    );

    assign {out_q, out_rmd, out_tag} = res_head_s;

    // Credit, in-flight and error next-state.
    always_comb begin
        credit_d   = credit_q;
        inflight_d = inflight_q;
        case ({accept_s, pop_s})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase
        case ({accept_s, collect_s})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (me_valid && (inflight_q == '0)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control state and the registered operand/start interface.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_q   <= CW'(DEPTH);
            inflight_q <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
        end else begin
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            start_q    <= accept_s;
            if (accept_s) begin
                a_q <= in_a;
                b_q <= in_b;
                c_q <= in_c;
                d_q <= in_d;
            end
        end
    end

    assign me_start = start_q;
    assign me_a     = a_q;
    assign me_b     = b_q;
    assign me_c     = c_q;
    assign me_d     = d_q;
    assign err      = err_q;
    assign busy     = (inflight_q != '0) || !res_empty_s;

endmodule

// File: tb/tb_me_issue_collect.sv
// Scoreboard bench for me_issue_collect with a fixed-latency math_expression stand-in.
module tb_me_issue_collect;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int QW    = 2 * W + 4;
    localparam int EW    = QW + 1 + TAG_W;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a, in_b, in_c, in_d;
    logic [TAG_W-1:0] in_tag;
    logic             me_start;
    logic [W-1:0]     me_a, me_b, me_c, me_d;
    logic             me_valid;
    logic [QW-1:0]    me_q;
    logic             me_rmd;
    logic             out_valid;
    logic             out_ready;
    logic [QW-1:0]    out_q;
    logic             out_rmd;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [EW-1:0]  exp_q [$];
    logic [4*W-1:0] iss_q [$];
    int             st_cyc [$];
    logic [EW-1:0]  mon_e;
    logic [4*W-1:0] mon_i;

    bit rr_en  = 1'b0;
    bit or_dir = 1'b1;
    bit inject = 1'b0;

    always #5 clk = ~clk;

    me_issue_collect #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_tag(in_tag),
        .me_start(me_start), .me_a(me_a), .me_b(me_b), .me_c(me_c), .me_d(me_d),
        .me_valid(me_valid), .me_q(me_q), .me_rmd(me_rmd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_rmd(out_rmd), .out_tag(out_tag),
        .busy(busy), .err(err)
    );

    // Stand-in math_expression result: q = a*b + c*d (signed), rmd = a[0]^d[0].
    function automatic logic [QW:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
        logic signed [QW-1:0] sa, sb, sc, sd, q;
        sa = QW'($signed(a));
        sb = QW'($signed(b));
        sc = QW'($signed(c));
        sd = QW'($signed(d));
        q  = sa * sb + sc * sd;
        return {q, a[0] ^ d[0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic note_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred that must not occur", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] d, input logic [TAG_W-1:0] t, input bit keep);
        int  n;
        bit  acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c; in_d = d; in_tag = t;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        if (!acc) note_fail("send_timeout");
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || iss_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) note_fail({nm, "_drain_timeout"});
        @(negedge clk);
        chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
        chk({nm, "_out_valid_idle"}, 64'(out_valid), 64'd0);
        step();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // out_ready driver: either directed or randomly toggled.
    initial begin
        out_ready = 1'b0;
        forever begin
            step();
            out_ready = rr_en ? ($urandom_range(0, 3) != 0) : or_dir;
        end
    end

    // math_expression stand-in: fixed latency, cleared by reset, optional spurious strobe.
    initial begin
        logic            s_rst, s_v;
        logic [QW:0]     s_d;
        logic [LAT-1:0]  pv;
        logic [QW:0]     pd [LAT];
        pv = '0;
        for (int i = 0; i < LAT; i++) pd[i] = '0;
        me_valid = 1'b0; me_q = '0; me_rmd = 1'b0;
        forever begin
            @(negedge clk);
            s_rst = reset;
            s_v   = me_start;
            s_d   = ref_res(me_a, me_b, me_c, me_d);
            step();
            if (!s_rst) begin
                pv = '0;
                me_valid = 1'b0; me_q = '0; me_rmd = 1'b0;
            end else begin
                me_valid = pv[LAT-1];
                {me_q, me_rmd} = pd[LAT-1];
                for (int i = LAT - 1; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pd[i] = pd[i-1];
                end
                pv[0] = s_v;
                pd[0] = s_d;
                if (inject) begin
                    me_valid = 1'b1;
                    me_q     = {4'hA, $urandom()};
                    me_rmd   = 1'b1;
                    inject   = 1'b0;
                end
            end
        end
    end

    // Monitor: checks issued operands and popped results against the scoreboard queues.
    initial forever begin
        @(negedge clk);
        if (me_start) begin
            st_cyc.push_back(cyc);
            if (iss_q.size() == 0) begin
                note_fail("unexpected_start");
            end else begin
                mon_i = iss_q.pop_front();
                chk("issue_ops", {me_a, me_b, me_c, me_d}, mon_i);
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                note_fail("stale_result");
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", 64'({out_q, out_rmd, out_tag}), 64'(mon_e));
            end
        end
        if (in_valid && in_ready) begin
            iss_q.push_back({in_a, in_b, in_c, in_d});
            exp_q.push_back({ref_res(in_a, in_b, in_c, in_d), in_tag});
        end
        if (!reset) begin
            exp_q.delete();
            iss_q.delete();
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  acc;
        int  n;
        bit  a;
        reset = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_tag = '0;

        // Reset behaviour.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        chk("rel_out_fields", 64'({out_q, out_rmd, out_tag}), 64'd0);
        chk("rel_me_start", 64'(me_start), 64'd0);
        chk("rel_me_ops", {me_a, me_b, me_c, me_d}, 64'd0);
        chk("rel_busy_err", 64'({busy, err}), 64'd0);
        step();

        // Single request.
        send(16'sd5, 16'sd3, 16'sd2, -16'sd1, 4'd1, 1'b0);
        drain("single");

        // Back-to-back requests must issue on adjacent cycles.
        st_cyc.delete();
        send(16'sd3, 16'sd3, -16'sd3, 16'sd3, 4'd2, 1'b1);
        send(16'sd32767, -16'sd1, 16'sd0, 16'sd0, 4'd3, 1'b0);
        drain("b2b");
        chk("b2b_pulses", 64'(st_cyc.size()), 64'd2);
        if (st_cyc.size() == 2) chk("b2b_adjacent", 64'(st_cyc[1] - st_cyc[0]), 64'd1);

        // Backpressure: six offered, only DEPTH accepted while the output is stalled.
        or_dir = 1'b0;
        step(); step();
        acc = 0;
        in_valid = 1'b1;
        in_a = W'($urandom()); in_b = W'($urandom()); in_c = W'($urandom()); in_d = W'($urandom());
        in_tag = TAG_W'(acc);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a = in_ready;
            step();
            if (a) begin
                acc++;
                in_a = W'($urandom()); in_b = W'($urandom()); in_c = W'($urandom()); in_d = W'($urandom());
                in_tag = TAG_W'(acc);
            end
        end
        chk("bp_accepted", 64'(acc), 64'(DEPTH));
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        or_dir = 1'b1;
        n = 0;
        a = 1'b0;
        while (!a && n < 20) begin
            @(negedge clk);
            a = out_valid && out_ready;
            n++;
        end
        if (!a) note_fail("bp_first_pop_timeout");
        @(negedge clk);
        chk("bp_credit_return", 64'(in_ready), 64'd1);
        a = in_ready;
        step();
        if (a) begin
            acc++;
            in_a = W'($urandom()); in_b = W'($urandom()); in_c = W'($urandom()); in_d = W'($urandom());
            in_tag = TAG_W'(acc);
        end
        n = 0;
        while (acc < 6 && n < 50) begin
            @(negedge clk);
            a = in_ready;
            step();
            n++;
            if (a) begin
                acc++;
                in_a = W'($urandom()); in_b = W'($urandom()); in_c = W'($urandom()); in_d = W'($urandom());
                in_tag = TAG_W'(acc);
            end
        end
        in_valid = 1'b0;
        chk("bp_total_accepted", 64'(acc), 64'd6);
        drain("bp");

        // Spurious strobe with nothing in flight.
        @(negedge clk);
        inject = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur_err", 64'(err), 64'd1);
        chk("spur_out_valid", 64'(out_valid), 64'd0);
        repeat (4) @(negedge clk);
        chk("spur_err_sticky", 64'(err), 64'd1);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("spur_err_cleared", 64'(err), 64'd0);
        step();

        // Reset while two requests are in flight.
        send(W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()), 4'd7, 1'b1);
        send(W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()), 4'd8, 1'b0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_err", 64'(err), 64'd0);
        step();

        // Random traffic with random output stalls.
        rr_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send(W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()), TAG_W'($urandom()), 1'b0);
        end
        rr_en = 1'b0;
        drain("rand");
        chk("rand_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
